// File: rtl/limit_pkg.sv
// Shared types and constants for the multi-channel output limiter.
package limit_pkg;

    typedef enum logic [1:0] {
        TRACK   = 2'd0,
        RAILED  = 2'd1,
        CLEAR   = 2'd2,
        HOLDOFF = 2'd3
    } chan_state_e;

    localparam logic [1:0] RAIL_HI   = 2'b10;
    localparam logic [1:0] RAIL_LO   = 2'b01;
    localparam logic [1:0] RAIL_NONE = 2'b00;
    localparam logic [1:0] RAIL_CFG  = 2'b11;

    localparam int LIMIT_W  = 16;
    localparam int HEADROOM = 4;

endpackage

// File: rtl/limit_chan.sv
// One limiter channel: clamp against signed limits, rail-dwell FSM and
// one-cycle integrator-clear generation.
module limit_chan
    import limit_pkg::*;
#(
    parameter int SIGNAL_IN_SIZE  = 16,
    parameter int SIGNAL_OUT_SIZE = 16,
    parameter int DWELL_W         = 16
) (
    input  logic                                     clk_in,
    input  logic                                     rst_n_in,
    input  logic                                     valid,
    input  logic signed [LIMIT_W-1:0]                minval,
    input  logic signed [LIMIT_W-1:0]                maxval,
    input  logic                                     center_en,
    input  logic        [DWELL_W-1:0]                rail_hold,
    input  logic signed [SIGNAL_IN_SIZE+HEADROOM-1:0] sample,
    output logic signed [SIGNAL_OUT_SIZE-1:0]        limited,
    output logic        [1:0]                        railed,
    output logic                                     clear,
    output logic                                     cfg_err
);

    localparam int CMP_W = LIMIT_W + HEADROOM;
    localparam int SCALE = SIGNAL_OUT_SIZE - LIMIT_W;
    localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] CNT_ONE  = DWELL_W'(1);
    localparam logic [DWELL_W-1:0] CNT_MAX  = {DWELL_W{1'b1}};

    logic signed [CMP_W-1:0]           top_s;
    logic signed [CMP_W-1:0]           min_ext_s;
    logic signed [CMP_W-1:0]           max_ext_s;
    logic signed [SIGNAL_OUT_SIZE-1:0] min_sc_s;
    logic signed [SIGNAL_OUT_SIZE-1:0] max_sc_s;
    logic signed [SIGNAL_OUT_SIZE-1:0] pass_s;
    logic signed [SIGNAL_OUT_SIZE-1:0] next_out_s;
    logic        [1:0]                 next_rail_s;
    logic                              hi_s;
    logic                              lo_s;
    logic                              err_s;
    logic                              rail_any_s;
    logic        [DWELL_W-1:0]         hold_eff_s;
    logic        [DWELL_W-1:0]         cnt_inc_s;

    chan_state_e                       state_r;
    logic        [DWELL_W-1:0]         cnt_r;
    logic signed [SIGNAL_OUT_SIZE-1:0] limited_r;
    logic        [1:0]                 railed_r;
    logic                              clear_r;
    logic                              cfg_err_r;

    // The top 20 bits carry the headroom, so out-of-range samples compare correctly
    assign top_s      = sample[SIGNAL_IN_SIZE+HEADROOM-1 -: CMP_W];
    assign min_ext_s  = CMP_W'(minval);
    assign max_ext_s  = CMP_W'(maxval);
    assign min_sc_s   = SIGNAL_OUT_SIZE'(minval) <<< SCALE;
    assign max_sc_s   = SIGNAL_OUT_SIZE'(maxval) <<< SCALE;
    assign pass_s     = sample[SIGNAL_IN_SIZE-1 -: SIGNAL_OUT_SIZE];
    assign hi_s       = top_s > max_ext_s;
    assign lo_s       = top_s < min_ext_s;
    assign err_s      = minval > maxval;
    assign rail_any_s = (hi_s | lo_s) & ~err_s;
    assign hold_eff_s = (rail_hold == CNT_ZERO) ? CNT_ONE : rail_hold;
    assign cnt_inc_s  = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;

    // Select the limited value and rail code for the current sample
    always_comb begin
        next_out_s  = pass_s;
        next_rail_s = RAIL_NONE;
        if (err_s) begin
            next_out_s  = min_sc_s;
            next_rail_s = RAIL_CFG;
        end else if (hi_s) begin
            next_out_s  = max_sc_s;
            next_rail_s = RAIL_HI;
        end else if (lo_s) begin
            next_out_s  = min_sc_s;
            next_rail_s = RAIL_LO;
        end else begin
            next_out_s  = pass_s;
            next_rail_s = RAIL_NONE;
        end
    end

    // Output registers and rail-dwell FSM
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r   <= TRACK;
            cnt_r     <= CNT_ZERO;
            limited_r <= '0;
            railed_r  <= RAIL_NONE;
            clear_r   <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            clear_r   <= 1'b0;
            cfg_err_r <= err_s;
            if (valid) begin
                limited_r <= next_out_s;
                railed_r  <= next_rail_s;
            end else begin
                limited_r <= limited_r;
                railed_r  <= railed_r;
            end
            case (state_r)
                TRACK, HOLDOFF: begin
                    if (valid && rail_any_s) begin
                        cnt_r <= CNT_ONE;
                        if (center_en && (CNT_ONE >= hold_eff_s)) begin
                            state_r <= CLEAR;
                            clear_r <= 1'b1;
                        end else begin
                            state_r <= RAILED;
                        end
                    end else if (valid) begin
                        state_r <= TRACK;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        state_r <= state_r;
                    end
                end
                RAILED: begin
                    if (valid && rail_any_s) begin
                        // hi->lo jumps keep counting; the dwell is about being railed at all
                        cnt_r <= cnt_inc_s;
                        if (center_en && (cnt_inc_s >= hold_eff_s)) begin
                            state_r <= CLEAR;
                            clear_r <= 1'b1;
                        end else begin
                            state_r <= RAILED;
                        end
                    end else if (valid) begin
                        state_r <= TRACK;
                        cnt_r   <= CNT_ZERO;
                    end else begin
                        state_r <= RAILED;
                    end
                end
                CLEAR: begin
                    state_r <= HOLDOFF;
                    cnt_r   <= CNT_ZERO;
                end
                default: begin
                    state_r <= TRACK;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign limited = limited_r;
    assign railed  = railed_r;
    assign clear   = clear_r;
    assign cfg_err = cfg_err_r;

endmodule

// File: rtl/limit_multi.sv
// N-channel servo output limiter: parallel limit_chan instances plus shared
// valid pipeline and sticky rail status.
module limit_multi
    import limit_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int SIGNAL_IN_SIZE  = 16,
    parameter int SIGNAL_OUT_SIZE = 16,
    parameter int DWELL_W         = 16
) (
    input  logic                                          clk_in,
    input  logic                                          rst_n_in,
    input  logic                                          valid_in,
    input  logic [LIMIT_W*N_CH-1:0]                       minval_in,
    input  logic [LIMIT_W*N_CH-1:0]                       maxval_in,
    input  logic [N_CH-1:0]                               center_when_railed_in,
    input  logic [DWELL_W-1:0]                            rail_hold_in,
    input  logic                                          status_clr_in,
    input  logic [(SIGNAL_IN_SIZE+HEADROOM)*N_CH-1:0]     signal_in,
    output logic                                          valid_out,
    output logic [SIGNAL_OUT_SIZE*N_CH-1:0]               signal_out,
    output logic [2*N_CH-1:0]                             railed_out,
    output logic [2*N_CH-1:0]                             railed_sticky_out,
    output logic [N_CH-1:0]                               clear_out,
    output logic [N_CH-1:0]                               cfg_err_out
);

    localparam int IW = SIGNAL_IN_SIZE + HEADROOM;

    logic              valid_r;
    logic [2*N_CH-1:0] sticky_r;

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        limit_chan #(
            .SIGNAL_IN_SIZE (SIGNAL_IN_SIZE),
            .SIGNAL_OUT_SIZE(SIGNAL_OUT_SIZE),
            .DWELL_W        (DWELL_W)
        ) u_chan (
            .clk_in   (clk_in),
            .rst_n_in (rst_n_in),
            .valid    (valid_in),
            .minval   (minval_in[LIMIT_W*k +: LIMIT_W]),
            .maxval   (maxval_in[LIMIT_W*k +: LIMIT_W]),
            .center_en(center_when_railed_in[k]),
            .rail_hold(rail_hold_in),
            .sample   (signal_in[IW*k +: IW]),
            .limited  (signal_out[SIGNAL_OUT_SIZE*k +: SIGNAL_OUT_SIZE]),
            .railed   (railed_out[2*k +: 2]),
            .clear    (clear_out[k]),
            .cfg_err  (cfg_err_out[k])
        );
    end

    // Valid delay and sticky rail flags; a rail seen during a clear survives it
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_r  <= 1'b0;
            sticky_r <= '0;
        end else begin
            valid_r <= valid_in;
            if (status_clr_in) begin
                sticky_r <= railed_out;
            end else begin
                sticky_r <= sticky_r | railed_out;
            end
        end
    end

    assign valid_out         = valid_r;
    assign railed_sticky_out = sticky_r;

endmodule

// File: tb/tb_limit_multi.sv
// Self-checking bench for limit_multi: a 2-channel 16/16 instance and a
// 4-channel 24/20 instance, checked through per-instance scoreboards.
module tb_limit_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Instance A: N_CH=2, IN=OUT=16
    logic        va, vo_a, clra;
    logic [39:0] sa;
    logic [31:0] mina, maxa, so_a;
    logic [1:0]  cena, cla, cea;
    logic [15:0] holda;
    logic [3:0]  ra, rsa;

    // Instance B: N_CH=4, IN=24, OUT=20
    logic         vb, vo_b, clrb;
    logic [111:0] sb;
    logic [63:0]  minb, maxb;
    logic [79:0]  so_b;
    logic [3:0]   cenb, clb, ceb;
    logic [15:0]  holdb;
    logic [7:0]   rb, rsb;

    limit_multi #(.N_CH(2), .SIGNAL_IN_SIZE(16), .SIGNAL_OUT_SIZE(16), .DWELL_W(16)) u_a (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(va), .minval_in(mina), .maxval_in(maxa),
        .center_when_railed_in(cena), .rail_hold_in(holda), .status_clr_in(clra),
        .signal_in(sa), .valid_out(vo_a), .signal_out(so_a), .railed_out(ra),
        .railed_sticky_out(rsa), .clear_out(cla), .cfg_err_out(cea));

    limit_multi #(.N_CH(4), .SIGNAL_IN_SIZE(24), .SIGNAL_OUT_SIZE(20), .DWELL_W(16)) u_b (
        .clk_in(clk), .rst_n_in(rst_n), .valid_in(vb), .minval_in(minb), .maxval_in(maxb),
        .center_when_railed_in(cenb), .rail_hold_in(holdb), .status_clr_in(clrb),
        .signal_in(sb), .valid_out(vo_b), .signal_out(so_b), .railed_out(rb),
        .railed_sticky_out(rsb), .clear_out(clb), .cfg_err_out(ceb));

    typedef struct packed {
        logic [79:0] o;
        logic [7:0]  r;
        logic [3:0]  c;
    } exp_t;

    typedef struct {
        int s0, s1, o0, o1;
        logic [3:0] r;
    } avec_t;

    typedef struct {
        int s0, s1, s2, s3, o0, o1, o2, o3;
        logic [7:0] r;
    } bvec_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t la, lb;
    logic va_last, vb_last;
    int n_tests = 0;
    int n_fail  = 0;
    avec_t at[7];
    bvec_t bt[3];

    task automatic cmp(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_outs();
        exp_t e;
        cmp("a_valid_out", 80'(vo_a), 80'(va_last));
        if (vo_a) begin
            if (qa.size() == 0) begin
                cmp("a_scoreboard_empty", 80'(qa.size()), 80'd1);
            end else begin
                e = qa.pop_front();
                la = e;
                cmp("a_out", 80'(so_a), e.o);
                cmp("a_railed", 80'(ra), 80'(e.r));
                cmp("a_clear", 80'(cla), 80'(e.c));
            end
        end else begin
            cmp("a_hold_out", 80'(so_a), la.o);
            cmp("a_hold_railed", 80'(ra), 80'(la.r));
            cmp("a_clear_idle", 80'(cla), 80'd0);
        end
        cmp("b_valid_out", 80'(vo_b), 80'(vb_last));
        if (vo_b) begin
            if (qb.size() == 0) begin
                cmp("b_scoreboard_empty", 80'(qb.size()), 80'd1);
            end else begin
                e = qb.pop_front();
                lb = e;
                cmp("b_out", so_b, e.o);
                cmp("b_railed", 80'(rb), 80'(e.r));
                cmp("b_clear", 80'(clb), 80'(e.c));
            end
        end else begin
            cmp("b_hold_out", so_b, lb.o);
            cmp("b_hold_railed", 80'(rb), 80'(lb.r));
            cmp("b_clear_idle", 80'(clb), 80'd0);
        end
    endtask

    task automatic tick();
        va_last = va;
        vb_last = vb;
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic cyc_a(input logic v, input int s0, input int s1, input int o0, input int o1,
                         input logic [3:0] r, input logic [1:0] c);
        exp_t e;
        va = v;
        sa = {20'(s1), 20'(s0)};
        if (v) begin
            e = '0;
            e.o[31:0] = {16'(o1), 16'(o0)};
            e.r[3:0]  = r;
            e.c[1:0]  = c;
            qa.push_back(e);
        end
        tick();
        va = 1'b0;
    endtask

    task automatic cyc_b(input bvec_t t);
        exp_t e;
        vb = 1'b1;
        sb = {28'(t.s3), 28'(t.s2), 28'(t.s1), 28'(t.s0)};
        e = '0;
        e.o = {20'(t.o3), 20'(t.o2), 20'(t.o1), 20'(t.o0)};
        e.r = t.r;
        qb.push_back(e);
        tick();
        vb = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        cmp("rst_a_valid", 80'(vo_a), 80'd0);
        cmp("rst_a_out", 80'(so_a), 80'd0);
        cmp("rst_a_railed", 80'(ra), 80'd0);
        cmp("rst_a_sticky", 80'(rsa), 80'd0);
        cmp("rst_a_clear", 80'(cla), 80'd0);
        cmp("rst_a_cfg_err", 80'(cea), 80'd0);
        cmp("rst_b_valid", 80'(vo_b), 80'd0);
        cmp("rst_b_out", so_b, 80'd0);
        cmp("rst_b_railed", 80'(rb), 80'd0);
        cmp("rst_b_sticky", 80'(rsb), 80'd0);
        cmp("rst_b_clear", 80'(clb), 80'd0);
        cmp("rst_b_cfg_err", 80'(ceb), 80'd0);
        qa.delete();
        qb.delete();
        la = '0;
        lb = '0;
        va = 1'b0;
        vb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        va = 1'b0; vb = 1'b0; clra = 1'b0; clrb = 1'b0;
        sa = '0; sb = '0;
        mina = {16'(-200), 16'(-1000)};
        maxa = {16'(300), 16'(1000)};
        cena = 2'b00; holda = 16'd4;
        for (int k = 0; k < 4; k++) begin
            minb[16*k +: 16] = 16'(-100 * (k + 1));
            maxb[16*k +: 16] = 16'(50 * (k + 1));
        end
        cenb = 4'b0000; holdb = 16'd4;
        la = '0; lb = '0;

        at[0] = '{500, 0, 500, 0, 4'b0000};
        at[1] = '{1500, 301, 1000, 300, 4'b1010};
        at[2] = '{-1500, -201, -1000, -200, 4'b0101};
        at[3] = '{1000, -200, 1000, -200, 4'b0000};
        at[4] = '{-1000, 300, -1000, 300, 4'b0000};
        at[5] = '{1001, 299, 1000, 299, 4'b0010};
        at[6] = '{524287, -524288, 1000, -200, 4'b0110};

        bt[0] = '{7770, 38400, -77056, -102385, 485, 1600, -4800, -6400, 8'b00011000};
        bt[1] = '{-25856, 25855, 38656, -102656, -1600, 1615, 2400, -6400, 8'b01100001};
        bt[2] = '{134217727, 0, 0, 0, 800, 0, 0, 0, 8'b00000010};

        do_reset();

        // Basic clamp table, then idle hold and a limit change
        for (int i = 0; i < 7; i++) begin
            cyc_a(1'b1, at[i].s0, at[i].s1, at[i].o0, at[i].o1, at[i].r, 2'b00);
        end
        maxa[15:0] = 16'(500);
        cyc_a(1'b0, 7, 7, 0, 0, 4'b0000, 2'b00);
        cyc_a(1'b1, 800, 0, 500, 0, 4'b0010, 2'b00);
        maxa[15:0] = 16'(1000);
        do_reset();

        // Dwell to clear with back-to-back valids
        cena = 2'b01; holda = 16'd4;
        for (int i = 0; i < 6; i++) begin
            cyc_a(1'b1, 2000, 0, 1000, 0, 4'b0010, (i == 3) ? 2'b01 : 2'b00);
        end
        cyc_a(1'b0, 0, 0, 0, 0, 4'b0000, 2'b00);
        cyc_a(1'b1, 0, 0, 0, 0, 4'b0000, 2'b00);

        // Same dwell with a valid every third clock
        for (int i = 0; i < 6; i++) begin
            cyc_a(1'b1, 2000, 0, 1000, 0, 4'b0010, (i == 3) ? 2'b01 : 2'b00);
            cyc_a(1'b0, 0, 0, 0, 0, 4'b0000, 2'b00);
            cyc_a(1'b0, 0, 0, 0, 0, 4'b0000, 2'b00);
        end
        cyc_a(1'b1, 0, 0, 0, 0, 4'b0000, 2'b00);

        // hi->lo jump keeps the dwell running
        cyc_a(1'b1, 2000, 0, 1000, 0, 4'b0010, 2'b00);
        cyc_a(1'b1, 2000, 0, 1000, 0, 4'b0010, 2'b00);
        cyc_a(1'b1, -2000, 0, -1000, 0, 4'b0001, 2'b00);
        cyc_a(1'b1, -2000, 0, -1000, 0, 4'b0001, 2'b01);
        cyc_a(1'b0, 0, 0, 0, 0, 4'b0000, 2'b00);
        cyc_a(1'b1, 0, 0, 0, 0, 4'b0000, 2'b00);

        // Center disabled mid-dwell, re-enabled past the hold value
        cena = 2'b00;
        for (int i = 0; i < 5; i++) begin
            cyc_a(1'b1, 2000, 0, 1000, 0, 4'b0010, 2'b00);
        end
        cena = 2'b01;
        cyc_a(1'b1, 2000, 0, 1000, 0, 4'b0010, 2'b01);
        cyc_a(1'b0, 0, 0, 0, 0, 4'b0000, 2'b00);
        cyc_a(1'b1, 0, 0, 0, 0, 4'b0000, 2'b00);

        // Interrupted dwell never clears; sticky flags and status clear
        clra = 1'b1;
        cyc_a(1'b0, 0, 0, 0, 0, 4'b0000, 2'b00);
        clra = 1'b0;
        cmp("a_sticky_cleared", 80'(rsa), 80'd0);
        for (int i = 0; i < 3; i++) cyc_a(1'b1, 2000, 0, 1000, 0, 4'b0010, 2'b00);
        cyc_a(1'b1, 0, 0, 0, 0, 4'b0000, 2'b00);
        for (int i = 0; i < 3; i++) cyc_a(1'b1, 2000, 0, 1000, 0, 4'b0010, 2'b00);
        cyc_a(1'b1, 0, 0, 0, 0, 4'b0000, 2'b00);
        cyc_a(1'b0, 0, 0, 0, 0, 4'b0000, 2'b00);
        cyc_a(1'b0, 0, 0, 0, 0, 4'b0000, 2'b00);
        cmp("a_sticky_set", 80'(rsa), 80'(4'b0010));
        cyc_a(1'b0, 0, 0, 0, 0, 4'b0000, 2'b00);
        cmp("a_sticky_persist", 80'(rsa), 80'(4'b0010));
        clra = 1'b1;
        cyc_a(1'b0, 0, 0, 0, 0, 4'b0000, 2'b00);
        clra = 1'b0;
        cmp("a_sticky_clr", 80'(rsa), 80'd0);
        cyc_a(1'b1, 2000, 0, 1000, 0, 4'b0010, 2'b00);
        clra = 1'b1;
        cyc_a(1'b0, 0, 0, 0, 0, 4'b0000, 2'b00);
        clra = 1'b0;
        cmp("a_sticky_set_wins", 80'(rsa), 80'(4'b0010));
        cyc_a(1'b1, 0, 0, 0, 0, 4'b0000, 2'b00);

        // Inverted limits on ch1, then reset in the middle of a dwell
        mina = {16'(100), 16'(-1000)};
        maxa = {16'(-100), 16'(1000)};
        cena = 2'b11; holda = 16'd1;
        cyc_a(1'b0, 0, 0, 0, 0, 4'b0000, 2'b00);
        cmp("a_cfg_err", 80'(cea), 80'(2'b10));
        cyc_a(1'b1, 0, 0, 0, 100, 4'b1100, 2'b00);
        cyc_a(1'b1, 0, 500, 0, 100, 4'b1100, 2'b00);
        cyc_a(1'b1, 0, -500, 0, 100, 4'b1100, 2'b00);
        holda = 16'd10;
        for (int i = 0; i < 3; i++) cyc_a(1'b1, 2000, 0, 1000, 100, 4'b1110, 2'b00);
        mina = {16'(-200), 16'(-1000)};
        maxa = {16'(300), 16'(1000)};
        do_reset();
        holda = 16'd4;
        for (int i = 0; i < 4; i++) begin
            cyc_a(1'b1, 2000, 0, 1000, 0, 4'b0010, (i == 3) ? 2'b01 : 2'b00);
        end
        cyc_a(1'b0, 0, 0, 0, 0, 4'b0000, 2'b00);
        cyc_a(1'b1, 0, 0, 0, 0, 4'b0000, 2'b00);

        // Hold value 0 behaves as 1
        holda = 16'd0;
        cyc_a(1'b1, 2000, 0, 1000, 0, 4'b0010, 2'b01);
        cyc_a(1'b1, 2000, 0, 1000, 0, 4'b0010, 2'b00);
        cyc_a(1'b1, 2000, 0, 1000, 0, 4'b0010, 2'b01);

        // Wide instance: independent channels with scaled limits
        for (int i = 0; i < 3; i++) begin
            cyc_b(bt[i]);
        end
        tick();

        cmp("a_queue_drained", 80'(qa.size()), 80'd0);
        cmp("b_queue_drained", 80'(qb.size()), 80'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
